// File: rtl/synth_pkg.sv
// Shared types and widths for the voice / envelope / codec datapath.
// Also hosts the velocity-to-gain scaling used by the VCA.
package synth_pkg;

    localparam int ENV_W    = 16;
    localparam int SAMPLE_W = 24;
    localparam int VEL_W    = 7;

    typedef enum logic [2:0] {
        IDLE,
        ATTACK,
        DECAY,
        SUSTAIN,
        RELEASE
    } env_state_t;

    // gain = (env * (velocity + 1)) >> 7; velocity 127 therefore gives unity gain.
    function automatic logic [ENV_W-1:0] env_gain(
        input logic [ENV_W-1:0] env,
        input logic [VEL_W-1:0] vel
    );
        logic [VEL_W:0]       vel_p1;
        logic [ENV_W+VEL_W:0] prod;
        vel_p1 = {1'b0, vel} + {{VEL_W{1'b0}}, 1'b1};
        prod   = {{(VEL_W+1){1'b0}}, env} * {{ENV_W{1'b0}}, vel_p1};
        return prod[ENV_W+VEL_W-1:VEL_W];
    endfunction

endpackage

// File: rtl/env_vca.sv
// Two-stage VCA: stage 1 captures din and the envelope gain on the tick,
// stage 2 registers the floored signed product into dout.
module env_vca
    import synth_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [ENV_W-1:0]    env,
    input  logic [VEL_W-1:0]    velocity,
    input  logic [SAMPLE_W-1:0] din,
    input  logic                tick,
    output logic [SAMPLE_W-1:0] dout,
    output logic                dout_valid
);

    localparam int PROD_W = SAMPLE_W + ENV_W + 1;

    logic [SAMPLE_W-1:0] din_q;
    logic [ENV_W-1:0]    gain_q;
    logic                stage1_vld_q;
    logic [SAMPLE_W-1:0] dout_q;
    logic                dout_valid_q;
    logic [PROD_W-1:0]   prod;

    // Sign-extend din and zero-extend gain to the full product width, so the
    // low PROD_W bits are the exact two's-complement product; dropping the
    // 16 LSBs is then an arithmetic (flooring) shift.
    assign prod = {{(PROD_W-SAMPLE_W){din_q[SAMPLE_W-1]}}, din_q}
                * {{(PROD_W-ENV_W){1'b0}}, gain_q};

    always_ff @(posedge clk) begin
        if (rst) begin
            din_q        <= '0;
            gain_q       <= '0;
            stage1_vld_q <= 1'b0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
        end else begin
            stage1_vld_q <= tick;
            dout_valid_q <= stage1_vld_q;
            if (tick) begin
                din_q  <= din;
                gain_q <= env_gain(env, velocity);
            end
            if (stage1_vld_q) begin
                dout_q <= prod[SAMPLE_W+ENV_W-1:ENV_W];
            end
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;

endmodule

// File: rtl/adsr_envelope.sv
// ADSR envelope FSM and level register feeding the velocity-scaled VCA.
// Note events take priority over the level step of a coinciding sample tick.
module adsr_envelope
    import synth_pkg::*;
#(
    parameter int unsigned ATTACK_STEP   = 16384,
    parameter int unsigned DECAY_STEP    = 8192,
    parameter int unsigned SUSTAIN_LEVEL = 32768,
    parameter int unsigned RELEASE_STEP  = 16384
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sample_tick,
    input  logic                note_on,
    input  logic                note_off,
    input  logic [VEL_W-1:0]    velocity,
    input  logic [SAMPLE_W-1:0] din,
    output logic [SAMPLE_W-1:0] dout,
    output logic                dout_valid,
    output logic                active
);

    localparam logic [ENV_W-1:0] ATK16 = ENV_W'(ATTACK_STEP);
    localparam logic [ENV_W-1:0] DEC16 = ENV_W'(DECAY_STEP);
    localparam logic [ENV_W-1:0] SUS16 = ENV_W'(SUSTAIN_LEVEL);
    localparam logic [ENV_W-1:0] REL16 = ENV_W'(RELEASE_STEP);

    // One extra bit so overflow/underflow tests need no wrap-around.
    localparam logic [ENV_W:0] ATK_X       = {1'b0, ATK16};
    localparam logic [ENV_W:0] REL_X       = {1'b0, REL16};
    localparam logic [ENV_W:0] ENV_MAX     = {1'b0, {ENV_W{1'b1}}};
    localparam logic [ENV_W:0] DECAY_FLOOR = {1'b0, SUS16} + {1'b0, DEC16};

    env_state_t       state_q, state_d;
    logic [ENV_W-1:0] env_q, env_d;
    logic [VEL_W-1:0] vel_q, vel_d;
    logic             active_q;
    logic [ENV_W:0]   env_x;

    assign env_x = {1'b0, env_q};

    always_comb begin
        state_d = state_q;
        env_d   = env_q;
        vel_d   = vel_q;
        if (note_on) begin
            state_d = ATTACK;
            vel_d   = velocity;
        end else if (note_off && (state_q inside {ATTACK, DECAY, SUSTAIN})) begin
            state_d = RELEASE;
        end else if (sample_tick) begin
            case (state_q)
                IDLE: env_d = '0;
                ATTACK: begin
                    if (env_x + ATK_X >= ENV_MAX) begin
                        env_d   = '1;
                        state_d = DECAY;
                    end else begin
                        env_d = env_q + ATK16;
                    end
                end
                DECAY: begin
                    // env - DECAY_STEP <= SUSTAIN_LEVEL, rearranged to avoid underflow.
                    if (env_x <= DECAY_FLOOR) begin
                        env_d   = SUS16;
                        state_d = SUSTAIN;
                    end else begin
                        env_d = env_q - DEC16;
                    end
                end
                SUSTAIN: env_d = env_q;
                RELEASE: begin
                    if (env_x <= REL_X) begin
                        env_d   = '0;
                        state_d = IDLE;
                    end else begin
                        env_d = env_q - REL16;
                    end
                end
                default: begin
                    env_d   = '0;
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            env_q    <= '0;
            vel_q    <= '0;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            env_q    <= env_d;
            vel_q    <= vel_d;
            active_q <= (state_q != IDLE);
        end
    end

    assign active = active_q;

    env_vca u_vca (
        .clk        (clk),
        .rst        (rst),
        .env        (env_q),
        .velocity   (vel_q),
        .din        (din),
        .tick       (sample_tick),
        .dout       (dout),
        .dout_valid (dout_valid)
    );

endmodule

// File: tb/tb_adsr_envelope.sv
// Directed bench for adsr_envelope: a default-parameter instance plus one with
// SUSTAIN_LEVEL = 65535 for the full-scale gain checks.
module tb_adsr_envelope;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sample_tick = 1'b0;
    logic [23:0] din = '0;
    logic        note_on = 1'b0, note_off = 1'b0;
    logic [6:0]  velocity = '0;
    logic        note_on_s = 1'b0, note_off_s = 1'b0;
    logic [6:0]  velocity_s = '0;

    logic [23:0] dout, dout_s;
    logic        dout_valid, dout_valid_s;
    logic        active, active_s;

    int n_vec  = 0;
    int n_fail = 0;

    logic [23:0] r_dout, r_dout_s;
    logic        r_act1, r_act2;

    always #5 clk = ~clk;

    adsr_envelope dut (
        .clk         (clk),
        .rst         (rst),
        .sample_tick (sample_tick),
        .note_on     (note_on),
        .note_off    (note_off),
        .velocity    (velocity),
        .din         (din),
        .dout        (dout),
        .dout_valid  (dout_valid),
        .active      (active)
    );

    adsr_envelope #(.SUSTAIN_LEVEL(65535)) dut_s (
        .clk         (clk),
        .rst         (rst),
        .sample_tick (sample_tick),
        .note_on     (note_on_s),
        .note_off    (note_off_s),
        .velocity    (velocity_s),
        .din         (din),
        .dout        (dout_s),
        .dout_valid  (dout_valid_s),
        .active      (active_s)
    );

    task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%06h, expected 0x%06h", name, act, exp);
        end
    endtask

    // One sample tick (plus any events already driven), with latency checks;
    // captures both douts and the active flag after edges T+1 and T+2.
    task automatic do_tick(input logic [23:0] d);
        sample_tick = 1'b1;
        din         = d;
        @(posedge clk); #1;
        sample_tick = 1'b0;
        note_on     = 1'b0;
        note_off    = 1'b0;
        note_on_s   = 1'b0;
        note_off_s  = 1'b0;
        r_act1      = active;
        check("valid_early", {23'd0, dout_valid}, 24'd0);
        @(posedge clk); #1;
        check("valid_at_2clk", {23'd0, dout_valid}, 24'd1);
        check("valid_s_at_2clk", {23'd0, dout_valid_s}, 24'd1);
        r_dout   = dout;
        r_dout_s = dout_s;
        r_act2   = active;
        @(posedge clk); #1;
        check("valid_one_cycle", {23'd0, dout_valid}, 24'd0);
        repeat (5) @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic on, input logic off, input logic [6:0] vel,
                         input logic on_s, input logic [6:0] vel_s);
        note_on    = on;
        note_off   = off;
        velocity   = vel;
        note_on_s  = on_s;
        velocity_s = vel_s;
        @(posedge clk); #1;
        note_on   = 1'b0;
        note_off  = 1'b0;
        note_on_s = 1'b0;
    endtask

    typedef struct {
        logic [23:0] din;
        logic [23:0] exp;
        logic [23:0] exp_s;
    } vec_t;

    vec_t tab[11];

    initial begin
        // dout = env << 6 for din 0x400000 at velocity 127 (unity gain).
        tab[0]  = '{24'h400000, 24'h000000, 24'h000000};
        tab[1]  = '{24'h400000, 24'h100000, 24'h100000};
        tab[2]  = '{24'h400000, 24'h200000, 24'h200000};
        tab[3]  = '{24'h400000, 24'h300000, 24'h300000};
        tab[4]  = '{24'h400000, 24'h3FFFC0, 24'h3FFFC0};
        tab[5]  = '{24'h400000, 24'h37FFC0, 24'h3FFFC0};
        tab[6]  = '{24'h400000, 24'h2FFFC0, 24'h3FFFC0};
        tab[7]  = '{24'h400000, 24'h27FFC0, 24'h3FFFC0};
        tab[8]  = '{24'h400000, 24'h200000, 24'h3FFFC0};
        tab[9]  = '{24'h400000, 24'h200000, 24'h3FFFC0};
        tab[10] = '{24'hC00000, 24'hE00000, 24'hC00040};

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_dout", dout, 24'd0);
        check("reset_valid", {23'd0, dout_valid}, 24'd0);
        check("reset_active", {23'd0, active}, 24'd0);

        // Attack / decay / sustain contour on both instances.
        pulse(1'b1, 1'b0, 7'd127, 1'b1, 7'd127);
        for (int i = 0; i < 11; i++) begin
            do_tick(tab[i].din);
            check($sformatf("contour[%0d]", i), r_dout, tab[i].exp);
            check($sformatf("contour_s[%0d]", i), r_dout_s, tab[i].exp_s);
            check($sformatf("active[%0d]", i), {23'd0, r_act2}, 24'd1);
        end

        // Release from SUSTAIN at 32768.
        pulse(1'b0, 1'b1, 7'd127, 1'b0, 7'd127);
        do_tick(24'h400000);
        check("release_0", r_dout, 24'h200000);
        do_tick(24'h400000);
        check("release_1", r_dout, 24'h100000);
        check("release_active_t1", {23'd0, r_act1}, 24'd1);
        check("release_active_t2", {23'd0, r_act2}, 24'd0);

        // Velocity 63 at env 65535: gain 32767. dut is idle, so its dout is 0.
        pulse(1'b0, 1'b0, 7'd127, 1'b1, 7'd63);
        do_tick(24'h400000);
        check("idle_dout_zero", r_dout, 24'h000000);
        check("vel63_dout", r_dout_s, 24'h1FFFC0);

        // note_on and note_off together: ATTACK from 0.
        pulse(1'b1, 1'b1, 7'd127, 1'b0, 7'd63);
        do_tick(24'h400000);
        check("collide_0", r_dout, 24'h000000);
        check("collide_active", {23'd0, r_act2}, 24'd1);
        do_tick(24'h400000);
        check("collide_1", r_dout, 24'h100000);

        // note_on coinciding with a tick skips that step (env stays 32768).
        note_on = 1'b1;
        do_tick(24'h400000);
        check("onTick_0", r_dout, 24'h200000);
        do_tick(24'h400000);
        check("onTick_1", r_dout, 24'h200000);

        // Release from 49152 down to 16384, then retrigger.
        pulse(1'b0, 1'b1, 7'd127, 1'b0, 7'd63);
        do_tick(24'h400000);
        check("rel_49152", r_dout, 24'h300000);
        do_tick(24'h400000);
        check("rel_32768", r_dout, 24'h200000);
        pulse(1'b1, 1'b0, 7'd127, 1'b0, 7'd63);
        do_tick(24'h400000);
        check("retrig_16384", r_dout, 24'h100000);
        do_tick(24'h400000);
        check("retrig_32768", r_dout, 24'h200000);

        // Reset mid-ATTACK (env 49152) with a result in the pipeline.
        sample_tick = 1'b1;
        din         = 24'h400000;
        @(posedge clk); #1;
        sample_tick = 1'b0;
        rst         = 1'b1;
        @(posedge clk); #1;
        check("rst_mid_dout", dout, 24'd0);
        check("rst_mid_valid", {23'd0, dout_valid}, 24'd0);
        check("rst_mid_active", {23'd0, active}, 24'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("rst_flushed_valid", {23'd0, dout_valid}, 24'd0);
        do_tick(24'h400000);
        check("post_rst_dout", r_dout, 24'd0);
        check("post_rst_active", {23'd0, r_act2}, 24'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
